// File: rtl/conv_decoder_output_buffer.sv
// Output buffer of the conv decoder path: FIFO-queues signed pixels and streams one FRAME_LEN frame per start.
// Optional build macro CONV_DECODER_OUT_CLAMP_EN clamps negative head values to 0 at out_pixel.
module conv_decoder_output_buffer #(
    parameter int DATA_W    = 18,
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 784
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] y_in,
    input  logic                     y_valid,
    output logic                     in_ready,
    output logic signed [DATA_W-1:0] out_pixel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     frame_done,
    output logic                     busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FRAME_LEN + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [AW-1:0]            wr_ptr_q, rd_ptr_q, rd_ptr_inc;
    logic [CW-1:0]            count_q, count_d;
    logic [FW-1:0]            wr_cnt_q, rd_cnt_q;
    logic signed [DATA_W-1:0] head_q, head_d;
    logic                     frame_done_q;
    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic                     wr_en, rd_en;

    assign in_ready   = (state_q == S_RUN) && (count_q < CW'(DEPTH));
    assign out_valid  = (count_q != '0);
    assign out_last   = out_valid && (rd_cnt_q == FW'(FRAME_LEN - 1));
    assign wr_en      = y_valid && in_ready;
    assign rd_en      = out_valid && out_ready;
    assign rd_ptr_inc = rd_ptr_q + AW'(1);
    assign frame_done = frame_done_q;
    assign busy       = (state_q != S_IDLE);

`ifdef CONV_DECODER_OUT_CLAMP_EN
    assign out_pixel = head_q[DATA_W-1] ? '0 : head_q;
`else
    assign out_pixel = head_q;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= y_in;
        end
    end

    // The head register tracks the oldest entry; it keeps the last value read once the FIFO drains.
    always_comb begin
        head_d = head_q;
        if (rd_en) begin
            if (count_q > CW'(1)) begin
                head_d = mem_q[rd_ptr_inc];
            end else if (wr_en) begin
                head_d = y_in;
            end
        end else if (wr_en && (count_q == '0)) begin
            head_d = y_in;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (wr_en && (wr_cnt_q == FW'(FRAME_LEN - 1))) state_d = S_DRAIN;
            S_DRAIN: if (rd_en && out_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wr_cnt_q     <= '0;
            rd_cnt_q     <= '0;
            head_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            head_q       <= head_d;
            frame_done_q <= (state_q == S_DRAIN) && rd_en && out_last;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_inc;
            end
            if ((state_q == S_IDLE) && start) begin
                wr_cnt_q <= '0;
                rd_cnt_q <= '0;
            end else begin
                if (wr_en) wr_cnt_q <= wr_cnt_q + FW'(1);
                if (rd_en) rd_cnt_q <= rd_cnt_q + FW'(1);
            end
        end
    end

endmodule

// File: tb/tb_conv_decoder_output_buffer.sv
// Scoreboard bench for conv_decoder_output_buffer with DEPTH=4, FRAME_LEN=6.
module tb_conv_decoder_output_buffer;

    localparam int DW = 18;
    localparam int FL = 6;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic signed [DW-1:0] y_in = '0;
    logic                 y_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] out_pixel;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic                 out_last;
    logic                 frame_done;
    logic                 busy;

    typedef struct {
        logic signed [DW-1:0] d;
        logic                 last;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   tb_wr = 0;
    int   n_reads = 0;
    int   n_done = 0;

    conv_decoder_output_buffer #(.DATA_W(DW), .DEPTH(4), .FRAME_LEN(FL)) dut (
        .clk(clk), .rst(rst), .start(start), .y_in(y_in), .y_valid(y_valid),
        .in_ready(in_ready), .out_pixel(out_pixel), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic signed [DW-1:0] expect_pix(input logic signed [DW-1:0] v);
`ifdef CONV_DECODER_OUT_CLAMP_EN
        return (v < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    // Monitor: handshakes seen at negedge complete on the following rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_reads++;
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: read pixel %0d with nothing expected", out_pixel);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (out_pixel !== e.d || out_last !== e.last) begin
                        n_fail++;
                        $display("FAIL sb_read: got pixel %0d last %0b, want pixel %0d last %0b",
                                 out_pixel, out_last, e.d, e.last);
                    end
                    $display("read  pixel=%0d last=%0b", out_pixel, out_last);
                end
            end
            if (y_valid && in_ready) begin
                exp_t e;
                e.d = expect_pix(y_in);
                e.last = (tb_wr == FL - 1);
                sb_q.push_back(e);
                tb_wr++;
                $display("write pixel=%0d", y_in);
            end
            if (frame_done) n_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tb_wr = 0;
        n_reads = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_pixel !== '0 || out_last !== 1'b0 ||
            frame_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out_pixel=%0d out_last=%b frame_done=%b busy=%b, want all 0",
                     in_ready, out_valid, out_pixel, out_last, frame_done, busy);
        end
        tick();
    endtask

    task automatic test_stream();
        int done0;
        do_start();
        out_ready = 1'b1;
        for (int i = 1; i <= FL; i++) begin
            y_in = DW'(i);
            y_valid = 1'b1;
            @(negedge clk);
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_in_ready: pixel %0d got %b want 1", i, in_ready);
            end
            if (i > 1) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_pixel !== DW'(i - 1)) begin
                    n_fail++;
                    $display("FAIL stream_latency: got valid %b pixel %0d want valid 1 pixel %0d",
                             out_valid, out_pixel, i - 1);
                end
            end
            tick();
        end
        y_valid = 1'b0;
        done0 = n_done;
        @(negedge clk);
        n_checks++;
        if (out_pixel !== DW'(FL) || out_last !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_last: got pixel %0d last %b busy %b want %0d 1 1", out_pixel, out_last, busy, FL);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_done: got frame_done %b busy %b want 1 0", frame_done, busy);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (frame_done !== 1'b0 || (n_done - done0) != 1 || n_reads != FL) begin
            n_fail++;
            $display("FAIL stream_pulse: frame_done %b pulses %0d reads %0d want 0 1 %0d",
                     frame_done, n_done - done0, n_reads, FL);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int k = 1;
        int acc;
        int done0 = n_done;
        do_start();
        out_ready = 1'b0;
        y_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            y_in = DW'(k);
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc != 0) k++;
        end
        y_in = DW'(k);
        n_checks++;
        if (k != 5) begin
            n_fail++;
            $display("FAIL bp_accepted: got %0d writes want 4", k - 1);
        end
        // Full FIFO with a read this cycle: the write must still be refused.
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_read_no_write: in_ready %b out_valid %b want 0 1", in_ready, out_valid);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL after_full_accept: in_ready %b want 1", in_ready);
        end
        for (int c = 0; c < 30 && k <= FL; c++) begin
            y_in = DW'(k);
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc != 0) k++;
        end
        y_valid = 1'b0;
        for (int c = 0; c < 30 && n_done == done0; c++) tick();
        n_checks++;
        if (n_done - done0 != 1 || n_reads != FL || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_frame: pulses %0d reads %0d left %0d want 1 %0d 0",
                     n_done - done0, n_reads, sb_q.size(), FL);
        end
        out_ready = 1'b0;
        tick();
    endtask

    task automatic test_ignored();
        int done0 = n_done;
        y_valid = 1'b1;
        y_in = DW'(99);
        tick();
        tick();
        y_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ignore: out_valid %b in_ready %b busy %b want 0 0 0", out_valid, in_ready, busy);
        end
        do_start();
        out_ready = 1'b1;
        y_valid = 1'b1;
        for (int i = 1; i <= FL; i++) begin
            y_in = DW'(10 + i);
            start = (i == 3);
            tick();
        end
        start = 1'b0;
        y_in = DW'(77);
        for (int c = 0; c < 30 && n_done == done0; c++) tick();
        tick();
        y_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (n_reads != FL || (n_done - done0) != 1 || out_valid !== 1'b0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL ignore_frame: reads %0d pulses %0d out_valid %b left %0d want %0d 1 0 0",
                     n_reads, n_done - done0, out_valid, sb_q.size(), FL);
        end
        out_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int done0;
        do_start();
        out_ready = 1'b0;
        y_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            y_in = DW'(20 + i);
            tick();
        end
        y_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        done0 = n_done;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb_q.delete();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: out_valid %b in_ready %b busy %b frame_done %b want 0 0 0 0",
                     out_valid, in_ready, busy, frame_done);
        end
        tick();
        tick();
        n_checks++;
        if (n_done != done0) begin
            n_fail++;
            $display("FAIL mid_reset_done: got %0d pulses want 0", n_done - done0);
        end
        test_stream();
    endtask

    task automatic test_values();
        logic signed [DW-1:0] vals [FL];
        int done0 = n_done;
        vals[0] = -18'sd5;
        vals[1] = 18'sd7;
        vals[2] = -18'sd131072;
        vals[3] = 18'sd1;
        vals[4] = -18'sd1;
        vals[5] = 18'sd131071;
        do_start();
        out_ready = 1'b1;
        y_valid = 1'b1;
        for (int i = 0; i < FL; i++) begin
            y_in = vals[i];
            tick();
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_pixel !== expect_pix(vals[i])) begin
                n_fail++;
                $display("FAIL value_%0d: got %0d want %0d", i, out_pixel, expect_pix(vals[i]));
            end
        end
        y_valid = 1'b0;
        for (int c = 0; c < 30 && n_done == done0; c++) tick();
        n_checks++;
        if (n_done - done0 != 1) begin
            n_fail++;
            $display("FAIL value_frame: pulses %0d want 1", n_done - done0);
        end
        out_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_ignored();
        test_reset_mid();
        test_values();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1);
    end

endmodule

// File: doc/conv_decoder_output_buffer.md
Name: conv_decoder_output_buffer

Overview:
- Output-side buffer of the conv decoder path. It accepts signed 18-bit decoder result pixels and queues them in a small FIFO.
- It streams the pixels to the downstream consumer over a valid/ready handshake and frames each image as FRAME_LEN pixels.
- `start` arms one frame. `frame_done` pulses once the last pixel of the frame has left the block.

Parameters:
- DATA_W, 18: pixel width, signed two's complement.
- DEPTH, 16: FIFO entries; must be a power of two and at least 2.
- FRAME_LEN, 784: pixels per frame (28x28); must be at least 1.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  arms one frame; sampled only in IDLE.
- y_in  input  DATA_W  signed decoder result pixel.
- y_valid  input  1  y_in is valid this cycle.
- in_ready  output  1  block can accept y_in this cycle.
- out_pixel  output  DATA_W  signed pixel at the FIFO head.
- out_valid  output  1  out_pixel is valid.
- out_ready  input  1  downstream accepts out_pixel.
- out_last  output  1  out_pixel is the final pixel of the frame.
- frame_done  output  1  one-cycle pulse after the last pixel is read.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset: state=IDLE; FIFO empty; wr_cnt=0; rd_cnt=0. Outputs: in_ready=0, out_valid=0, out_pixel=0, out_last=0, frame_done=0, busy=0.
- Write: occurs when y_valid && in_ready. Read: occurs when out_valid && out_ready.
- in_ready = (state==RUN) && (count<DEPTH). It never depends on out_ready, so there is no write in the cycle the FIFO is full, even if a read also happens.
- out_valid = (count!=0). out_pixel equals FIFO head data. When the FIFO is empty, out_pixel holds its last value (0 after reset).
- Latency: a pixel written in cycle N is visible at out_pixel/out_valid in cycle N+1.
- Simultaneous write and read with 0<count<DEPTH: count is unchanged and both pointers advance.
- Pointers: log2(DEPTH) bits; wrap modulo DEPTH. count has log2(DEPTH)+1 bits.
- wr_cnt increments on each write. rd_cnt increments on each read.
- out_last = out_valid && (rd_cnt==FRAME_LEN-1).
- FSM states and transitions:
  - IDLE: start=1 -> RUN. wr_cnt and rd_cnt are cleared on entry to RUN.
  - RUN: a write that makes wr_cnt reach FRAME_LEN -> DRAIN. in_ready is 0 from the next cycle.
  - DRAIN: in_ready=0. A read with out_last=1 -> IDLE, with frame_done=1 for exactly the next cycle.
- FRAME_LEN=1: the single write moves RUN -> DRAIN. The read of that pixel carries out_last=1.
- start while in RUN or DRAIN is ignored. y_valid in IDLE or DRAIN is ignored and nothing is stored.
- Reset mid-frame: queued data is discarded. The block returns to the reset state in the next cycle with no frame_done pulse.
- Data passes through unmodified unless the optional feature is enabled.

Optional Feature:
- Macro: CONV_DECODER_OUT_CLAMP_EN.
- Defined: out_pixel is clamped to 0 whenever the head value is negative (MSB=1), combinationally at the output. FIFO contents are unchanged. Handshake, out_last and counters are unaffected.
- Undefined: out_pixel equals the stored value bit-exactly.

Test Plan (bench overrides DEPTH=4, FRAME_LEN=6):
- Reset, then start, then y_in = 1,2,3,4,5,6 with y_valid held and out_ready=1 -> out_pixel sequence 1..6, each one cycle after its write. out_last=1 only on 6. frame_done pulses one cycle after reading 6. busy returns to 0.
- Hold out_ready=0 and offer 6 pixels -> in_ready drops after 4 writes (count=4). Set out_ready=1 -> the remaining 2 are accepted. Read order is exactly 1..6 across pointer wrap.
- FIFO full (count=4), out_ready=1 and y_valid=1 in the same cycle -> read occurs, no write, count=3. The next cycle accepts the write.
- y_valid pulses before start and again after the 6th write -> nothing is stored. A start pulse during RUN -> no effect. Exactly 6 pixels are output.
- Assert rst after 3 writes and 1 read -> next cycle out_valid=0, in_ready=0, busy=0, no frame_done. A fresh frame then runs normally.
- With CONV_DECODER_OUT_CLAMP_EN defined, write -5, 7, -131072 -> out_pixel 0, 7, 0. Without it -> -5, 7, -131072.
